// File: rtl/tempsens_core_emu.sv
// rtl/tempsens_core_emu.sv - cycle-based digital stand-in for the analog temperature-sensor core
// Optional LFSR delay jitter: define TEMPSENS_EMU_JITTER_EN.
module tempsens_core_emu #(
    parameter int DAC_RESOLUTION = 6,
    parameter int N_TCODE        = 8,
    parameter int N_CNT          = 20,
    parameter int BASE_DELAY     = 4,
    parameter int DAC_SHIFT      = 2,
    parameter int MIN_PRECHARGE  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DAC_RESOLUTION-1:0] i_dac_data,
    input  logic                      i_dac_en,
    input  logic                      i_precharge_n,
    input  logic [N_TCODE-1:0]        i_temp_code,
    output logic                      o_tempdelay,
    output logic                      o_busy,
    output logic                      o_err_short,
    output logic                      o_err_stall
);

    localparam int TW  = N_CNT + 2;
    localparam int PCW = $clog2(MIN_PRECHARGE + 2);
    localparam logic [PCW-1:0] PC_MAX = PCW'(MIN_PRECHARGE);
    localparam logic [TW-1:0]  SAT_W  = {2'b00, {N_CNT{1'b1}}};

    typedef enum logic [1:0] {
        ST_PRECHARGE = 2'd0,
        ST_DISCHARGE = 2'd1,
        ST_FIRED     = 2'd2,
        ST_STALL     = 2'd3
    } state_t;

    state_t                    state;
    logic [PCW-1:0]            pc_cnt;
    logic [N_CNT-1:0]          cnt;
    logic [N_CNT-1:0]          target;
    logic [N_CNT-1:0]          target_next;
    logic [TW-1:0]             sum_w;
    logic [DAC_RESOLUTION-1:0] dac_inv;

    // Inverted code equals (2^DAC_RESOLUTION-1 - i_dac_data)
    assign dac_inv = ~i_dac_data;

`ifdef TEMPSENS_EMU_JITTER_EN
    logic [15:0] lfsr;
    logic [TW-1:0] jit_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Offset -1/0/0/+1 carried as +0/+1/+1/+2 so the sum never goes negative
    always_comb begin
        jit_p1 = TW'(1);
        if (lfsr[1:0] == 2'b00) begin
            jit_p1 = '0;
        end else if (lfsr[1:0] == 2'b11) begin
            jit_p1 = TW'(2);
        end
    end
`endif

    always_comb begin
        sum_w = TW'(BASE_DELAY) + TW'(i_temp_code) + (TW'(dac_inv) << DAC_SHIFT);
`ifdef TEMPSENS_EMU_JITTER_EN
        sum_w = sum_w + jit_p1;
        if (sum_w > TW'(1)) begin
            sum_w = sum_w - TW'(1);
        end else begin
            sum_w = '0;
        end
`endif
        if (sum_w > SAT_W) begin
            target_next = '1;
        end else if (sum_w == '0) begin
            target_next = N_CNT'(1);
        end else begin
            target_next = sum_w[N_CNT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_PRECHARGE;
            pc_cnt      <= '0;
            cnt         <= '0;
            target      <= '0;
            o_tempdelay <= 1'b0;
            o_busy      <= 1'b0;
            o_err_short <= 1'b0;
            o_err_stall <= 1'b0;
        end else if (!i_precharge_n) begin
            // Precharge overrides fire and stall from any state
            state       <= ST_PRECHARGE;
            o_tempdelay <= 1'b0;
            o_busy      <= 1'b0;
            if (state != ST_PRECHARGE) begin
                pc_cnt <= PCW'(1);
            end else if (pc_cnt < PC_MAX) begin
                pc_cnt <= pc_cnt + PCW'(1);
            end
        end else begin
            case (state)
                ST_PRECHARGE: begin
                    pc_cnt      <= '0;
                    o_tempdelay <= 1'b0;
                    if (pc_cnt < PC_MAX) begin
                        o_err_short <= 1'b1;
                    end
                    if (i_dac_en) begin
                        target <= target_next;
                        cnt    <= N_CNT'(1);
                        o_busy <= 1'b1;
                        state  <= ST_DISCHARGE;
                    end else begin
                        o_err_stall <= 1'b1;
                        state       <= ST_STALL;
                    end
                end
                ST_DISCHARGE: begin
                    if (!i_dac_en) begin
                        o_err_stall <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= ST_STALL;
                    end else if (cnt == target) begin
                        o_tempdelay <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= ST_FIRED;
                    end else begin
                        cnt <= cnt + N_CNT'(1);
                    end
                end
                ST_FIRED: begin
                    o_tempdelay <= 1'b1;
                end
                default: begin
                    o_tempdelay <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tempsens_core_emu.md
Name: tempsens_core_emu

Overview:
Synthesizable, cycle-based digital stand-in for the analog temperature-sensor core. It is the responder to tempsens_ctrl: it consumes the DAC code, DAC enable and active-low precharge, and returns o_tempdelay after a delay set by an emulated temperature code and the DAC code. It replaces the analog core in all-digital regression and FPGA prototyping, so the controller's full measurement loop can be closed without mixed-mode simulation.

Parameters:
DAC_RESOLUTION, 6, width of i_dac_data
N_TCODE, 8, width of the emulated temperature code i_temp_code
N_CNT, 20, width of the delay counter and target; target saturates at 2^N_CNT-1
BASE_DELAY, 4, fixed delay offset in clk cycles, must be >= 1
DAC_SHIFT, 2, left shift applied to the inverted DAC code
MIN_PRECHARGE, 2, minimum precharge_n low cycles before a valid release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_dac_data  in  DAC_RESOLUTION  DAC code from controller
i_dac_en  in  1  DAC enable from controller
i_precharge_n  in  1  active-low precharge; a rising level starts discharge
i_temp_code  in  N_TCODE  emulated temperature; larger = slower
o_tempdelay  out  1  delay output; rises when emulated node crosses threshold
o_busy  out  1  high in DISCHARGE
o_err_short  out  1  sticky: precharge released before MIN_PRECHARGE cycles
o_err_stall  out  1  sticky: i_dac_en low at release or during DISCHARGE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on posedge clk.
- Reset: state=PRECHARGE, pc_cnt=0, cnt=0, target=0, o_tempdelay=0, o_busy=0, o_err_short=0, o_err_stall=0. Reset mid-discharge aborts immediately; the next edge after reset is deasserted behaves as PRECHARGE.
- Target arithmetic, computed at release only:
  - target = BASE_DELAY + i_temp_code + ((2^DAC_RESOLUTION-1 - i_dac_data) << DAC_SHIFT).
  - Computed N_CNT+2 bits wide, then saturated to 2^N_CNT-1.
  - Clamped to a minimum of 1.
- States:
  - PRECHARGE: o_tempdelay=0. While i_precharge_n=0, pc_cnt increments, saturating at MIN_PRECHARGE. On the first edge sampling i_precharge_n=1:
    - If pc_cnt < MIN_PRECHARGE, set o_err_short. Release still proceeds.
    - If i_dac_en=1: latch target, cnt=1, go to DISCHARGE.
    - Else: set o_err_stall, go to STALL.
    - pc_cnt clears on leaving PRECHARGE.
  - DISCHARGE: o_busy=1; cnt increments each edge.
    - When cnt==target, o_tempdelay is registered high on that edge; go to FIRED. Net: o_tempdelay is high exactly target edges after the release edge.
    - i_dac_data and i_temp_code changes are ignored once target is latched.
    - If i_dac_en=0 is sampled: set o_err_stall, go to STALL. No fire.
  - FIRED: o_tempdelay=1, held until i_precharge_n=0 is sampled.
  - STALL: o_tempdelay=0, held until i_precharge_n=0 is sampled.
- Precharge priority: i_precharge_n=0 sampled in any state forces PRECHARGE. o_tempdelay=0 and o_busy=0 on that same edge. pc_cnt restarts at 1. This path has priority over fire and stall.
- Simultaneous events: when cnt==target and i_dac_en=0 occur on the same edge, the stall takes priority and there is no fire.
- Error flags: sticky; cleared only by reset.
- o_busy: registered; high exactly while state==DISCHARGE.

Optional Feature:
Macro: TEMPSENS_EMU_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset) advances every clk.
  - At release, LFSR[1:0] is mapped to an offset of -1, 0, 0 or +1 cycle and added to target. The minimum-1 clamp and the saturation are applied after the offset.
- Not defined: no LFSR logic; delay is fully deterministic.
- All tests below assume the macro is undefined.

Test Plan:
All tests use the default parameters.
- Nominal conversion: reset; precharge_n=0 for 3 cycles; dac=60, temp=10, en=1; release. Required: o_tempdelay rises exactly 26 edges after the release edge (4+10+(3<<2)). It stays high until precharge_n=0, then is 0 on the next edge. No error flags set.
- Extremes: dac=63, temp=0 gives target=4. dac=0, temp=255 gives target=4+255+252=511. Check both against the release edge.
- Short precharge: precharge_n low for 1 cycle, then release with en=1. Required: o_err_short=1 and the conversion still fires after target cycles.
- Stall: release with en=0. Required: o_err_stall=1 and o_tempdelay stays 0 for 1000 cycles. Then precharge_n=0 followed by a normal run fires correctly, and the flag stays set.
- Abort and re-arm: precharge_n=0 at cycle 10 of a 26-cycle run. Required: o_busy=0 on the next edge and no fire. Change dac to 63 mid-run in a second run: the target is unchanged.
- Reset mid-DISCHARGE: all outputs are 0 on the edge after reset. A conversion after reset matches nominal timing.
